// File: rtl/memory_controller.sv
// memory_controller
//
// Memory-side responder for the core's instruction-fetch and load/store ports.
// Each accepted request is serialised onto the byte-wide RAM/IO bus, one byte
// per cycle, and answered with a single-cycle *_rdy pulse carrying the
// assembled little-endian data. Load/store requests take priority over
// fetches. Stores to the IO window wait while the IO buffer is full.
//
// Ports:
//   clk_in          rising-edge clock
//   rst_in          asynchronous active-low reset
//   rdy_in          global enable; low freezes all state
//   flush           misprediction flush (aborts reads, drops a pending rdy)
//   mem_din         RAM read byte (one-cycle read latency)
//   mem_dout        RAM write byte
//   mem_a           RAM byte address
//   mem_wr          write strobe (1 = write)
//   io_buffer_full  IO write buffer cannot accept
//   if_en/if_addr   word fetch request and address
//   if_rdy/if_data  fetch completion pulse and instruction word
//   ls_en/ls_wr     load/store request, 1 = store
//   ls_size         0 = byte, 1 = half, 2/3 = word
//   ls_addr         byte address, any alignment
//   ls_wdata        store data, sent LSB-first
//   ls_rdy/ls_rdata load/store completion pulse and zero-extended load data
module memory_controller #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_en,
    input  logic [31:0] if_addr,
    output logic        if_rdy,
    output logic [31:0] if_data,
    input  logic        ls_en,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_rdy,
    output logic [31:0] ls_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e      r_state, w_state;
    logic        r_is_ls, w_is_ls;
    logic [31:0] r_addr, w_addr;
    logic [31:0] r_wdata, w_wdata;
    logic [2:0]  r_nbytes, w_nbytes;
    // Edges elapsed since the accept edge E0 (address index / capture pointer)
    logic [2:0]  r_cnt, w_cnt;
    logic [31:0] r_buf, w_buf;
    // Set while a read is frozen; the next enabled edge restarts it from byte 0
    logic        r_restart, w_restart;
    logic [31:0] r_mem_a, w_mem_a;
    logic [7:0]  r_mem_dout, w_mem_dout;
    logic        r_mem_wr, w_mem_wr;
    logic        r_if_rdy, w_if_rdy;
    logic [31:0] r_if_data, w_if_data;
    logic        r_ls_rdy, w_ls_rdy;
    logic [31:0] r_ls_rdata, w_ls_rdata;

    logic        w_io_blocked;
    logic [2:0]  w_ls_nbytes;
    logic [1:0]  w_rd_idx;
    logic [7:0]  w_wbyte;

    assign w_io_blocked = ls_wr && (ls_addr[31:16] == IO_BASE[31:16]) && io_buffer_full;

    // Byte captured at edge E(k+2) is byte k
    assign w_rd_idx = r_cnt[1:0] - 2'd2;

    always_comb begin
        case (ls_size)
            2'd0:    w_ls_nbytes = 3'd1;
            2'd1:    w_ls_nbytes = 3'd2;
            default: w_ls_nbytes = 3'd4;
        endcase
    end

    always_comb begin
        case (r_cnt[1:0])
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    always_comb begin
        w_state    = r_state;
        w_is_ls    = r_is_ls;
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_nbytes   = r_nbytes;
        w_cnt      = r_cnt;
        w_buf      = r_buf;
        w_restart  = r_restart;
        w_mem_a    = r_mem_a;
        w_mem_dout = r_mem_dout;
        w_mem_wr   = r_mem_wr;
        w_if_rdy   = r_if_rdy;
        w_if_data  = r_if_data;
        w_ls_rdy   = r_ls_rdy;
        w_ls_rdata = r_ls_rdata;

        if (!rdy_in) begin
            if (r_state == StRead) begin
                w_restart = 1'b1;
            end
        end else begin
            w_restart = 1'b0;
            case (r_state)
                StIdle: begin
                    if (!flush) begin
                        if (ls_en) begin
                            // A blocked IO store also holds off any fetch
                            if (!w_io_blocked) begin
                                w_is_ls  = 1'b1;
                                w_addr   = ls_addr;
                                w_wdata  = ls_wdata;
                                w_nbytes = w_ls_nbytes;
                                w_mem_a  = ls_addr;
                                w_cnt    = 3'd1;
                                if (ls_wr) begin
                                    w_state    = StWrite;
                                    w_mem_wr   = 1'b1;
                                    w_mem_dout = ls_wdata[7:0];
                                end else begin
                                    w_state = StRead;
                                    w_buf   = '0;
                                end
                            end
                        end else if (if_en) begin
                            w_is_ls  = 1'b0;
                            w_addr   = if_addr;
                            w_nbytes = 3'd4;
                            w_mem_a  = if_addr;
                            w_cnt    = 3'd1;
                            w_buf    = '0;
                            w_state  = StRead;
                        end
                    end
                end
                StRead: begin
                    if (flush) begin
                        w_state = StIdle;
                    end else if (r_restart) begin
                        w_mem_a = r_addr;
                        w_cnt   = 3'd1;
                        w_buf   = '0;
                    end else begin
                        if (r_cnt < r_nbytes) begin
                            w_mem_a = r_addr + {29'd0, r_cnt};
                        end
                        if (r_cnt >= 3'd2) begin
                            w_buf[{w_rd_idx, 3'b000} +: 8] = mem_din;
                        end
                        if (r_cnt == r_nbytes + 3'd1) begin
                            w_state = StDone;
                            if (r_is_ls) begin
                                w_ls_rdy   = 1'b1;
                                w_ls_rdata = w_buf;
                            end else begin
                                w_if_rdy  = 1'b1;
                                w_if_data = w_buf;
                            end
                        end
                        w_cnt = r_cnt + 3'd1;
                    end
                end
                StWrite: begin
                    // flush is ignored here: committed stores always finish
                    if (r_cnt < r_nbytes) begin
                        w_mem_wr   = 1'b1;
                        w_mem_a    = r_addr + {29'd0, r_cnt};
                        w_mem_dout = w_wbyte;
                        w_cnt      = r_cnt + 3'd1;
                    end else begin
                        w_mem_wr = 1'b0;
                        w_ls_rdy = 1'b1;
                        w_state  = StDone;
                    end
                end
                StDone: begin
                    w_if_rdy = 1'b0;
                    w_ls_rdy = 1'b0;
                    w_state  = StIdle;
                end
                default: begin
                    w_state = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= StIdle;
            r_is_ls    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_nbytes   <= 3'd1;
            r_cnt      <= '0;
            r_buf      <= '0;
            r_restart  <= 1'b0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
            r_if_rdy   <= 1'b0;
            r_if_data  <= '0;
            r_ls_rdy   <= 1'b0;
            r_ls_rdata <= '0;
        end else begin
            r_state    <= w_state;
            r_is_ls    <= w_is_ls;
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_nbytes   <= w_nbytes;
            r_cnt      <= w_cnt;
            r_buf      <= w_buf;
            r_restart  <= w_restart;
            r_mem_a    <= w_mem_a;
            r_mem_dout <= w_mem_dout;
            r_mem_wr   <= w_mem_wr;
            r_if_rdy   <= w_if_rdy;
            r_if_data  <= w_if_data;
            r_ls_rdy   <= w_ls_rdy;
            r_ls_rdata <= w_ls_rdata;
        end
    end

    assign mem_a    = r_mem_a;
    assign mem_dout = r_mem_dout;
    // A frozen write must not strobe the bus
    assign mem_wr   = r_mem_wr & rdy_in;
    assign if_rdy   = r_if_rdy;
    assign if_data  = r_if_data;
    assign ls_rdy   = r_ls_rdy;
    assign ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller
//
// Self-checking bench for memory_controller. A byte RAM with one-cycle read
// latency answers the bus; a separate model memory holds the expected
// contents and predicts load data, latencies and the write-byte stream.
module tb_memory_controller;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        flush = 1'b0;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        if_en = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_rdy;
    logic [31:0] if_data;
    logic        ls_en = 1'b0;
    logic        ls_wr = 1'b0;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_rdy;
    logic [31:0] ls_rdata;

    int vectors = 0;
    int errors = 0;
    int both_cnt = 0;

    logic [7:0]  ram   [0:4095];
    logic [7:0]  model [0:4095];
    logic [39:0] wlog  [$];
    logic [31:0] amon  [$];

    memory_controller dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_en(if_en), .if_addr(if_addr), .if_rdy(if_rdy), .if_data(if_data),
        .ls_en(ls_en), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdy(ls_rdy), .ls_rdata(ls_rdata)
    );

    always #5 clk_in = ~clk_in;

    // RAM: 4 KiB aliased over the address space, one-cycle read latency
    always @(posedge clk_in) begin
        if (rst_in) begin
            if (mem_wr) begin
                ram[mem_a[11:0]] = mem_dout;
                wlog.push_back({mem_a, mem_dout});
            end
            mem_din <= ram[mem_a[11:0]];
            if (if_rdy && ls_rdy) both_cnt++;
        end
    end

    function automatic int nb(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input int n);
        logic [31:0] v = '0;
        logic [31:0] ak;
        for (int k = 0; k < n; k++) begin
            ak = a + k;
            v = v | ({24'd0, model[ak[11:0]]} << (8 * k));
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input int n);
        logic [31:0] ak;
        logic [31:0] sh;
        for (int k = 0; k < n; k++) begin
            ak = a + k;
            sh = d >> (8 * k);
            model[ak[11:0]] = sh[7:0];
        end
    endtask

    // {count, entries} of the write stream, for one-shot comparison
    function automatic logic [167:0] pack_log();
        logic [167:0] p = '0;
        p[167:160] = 8'(wlog.size());
        for (int i = 0; i < wlog.size() && i < 4; i++) p[40*i +: 40] = wlog[i];
        return p;
    endfunction

    function automatic logic [167:0] exp_log(input logic [31:0] a, input logic [31:0] d,
                                             input int n);
        logic [167:0] p = '0;
        logic [31:0] ak;
        logic [31:0] sh;
        p[167:160] = 8'(n);
        for (int k = 0; k < n; k++) begin
            ak = a + k;
            sh = d >> (8 * k);
            p[40*k +: 40] = {ak, sh[7:0]};
        end
        return p;
    endfunction

    task automatic setbyte(input logic [31:0] a, input logic [7:0] v);
        ram[a[11:0]] = v;
        model[a[11:0]] = v;
    endtask

    task automatic start_ls(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] d);
        @(negedge clk_in);
        ls_en = 1'b1; ls_wr = wr; ls_size = sz; ls_addr = a; ls_wdata = d;
        wlog.delete();
    endtask

    task automatic start_if(input logic [31:0] a);
        @(negedge clk_in);
        if_en = 1'b1; if_addr = a;
        wlog.delete();
    endtask

    // lat = index of the edge (E0 = 0) after which rdy was seen; -1 on timeout
    task automatic wait_rdy(input logic is_ls, output int lat, output logic [31:0] data);
        lat = -1;
        data = 'x;
        amon.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            amon.push_back(mem_a);
            if (is_ls ? ls_rdy : if_rdy) begin
                lat = i;
                data = is_ls ? ls_rdata : if_data;
                break;
            end
        end
        if (is_ls) ls_en = 1'b0; else if_en = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_in = 1'b0;
        repeat (3) @(negedge clk_in);
        vectors++;
        if ({mem_a, mem_dout, mem_wr, if_rdy, if_data, ls_rdy, ls_rdata} !== '0)
            begin errors++; $display("FAIL reset_outputs: mem_a=%h dout=%h wr=%b if_rdy=%b if_data=%h ls_rdy=%b ls_rdata=%h, required all 0", mem_a, mem_dout, mem_wr, if_rdy, if_data, ls_rdy, ls_rdata); end
        rst_in = 1'b1;
    endtask

    task automatic test_fetch();
        int lat;
        logic [31:0] d;
        setbyte(32'h4, 8'h13); setbyte(32'h5, 8'h05); setbyte(32'h6, 8'h10); setbyte(32'h7, 8'h00);
        start_if(32'h4);
        wait_rdy(1'b0, lat, d);
        vectors++;
        if (d !== 32'h0010_0513) begin errors++; $display("FAIL fetch_data: got %h required %h", d, 32'h0010_0513); end
        vectors++;
        if (lat != 5) begin errors++; $display("FAIL fetch_latency: got %0d required 5", lat); end
        vectors++;
        if (amon.size() < 4 || amon[0] !== 32'h4 || amon[1] !== 32'h5 || amon[2] !== 32'h6 || amon[3] !== 32'h7)
            begin errors++; $display("FAIL fetch_addr_seq: got %0d samples, first %h required 4,5,6,7", amon.size(), (amon.size() > 0) ? amon[0] : 32'hx); end
        vectors++;
        if (wlog.size() != 0) begin errors++; $display("FAIL fetch_no_write: got %0d write cycles required 0", wlog.size()); end
        @(negedge clk_in);
        vectors++;
        if (if_rdy !== 1'b0) begin errors++; $display("FAIL fetch_rdy_pulse: if_rdy=%b one cycle later, required 0", if_rdy); end
    endtask

    task automatic test_priority();
        int lat;
        logic [31:0] d;
        logic if_seen;
        setbyte(32'h100, 8'hAB);
        @(negedge clk_in);
        if_en = 1'b1; if_addr = 32'h8;
        ls_en = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h100;
        wait_rdy(1'b1, lat, d);
        if_seen = if_rdy;
        vectors++;
        if (d !== 32'h0000_00AB || lat != 2 || if_seen !== 1'b0)
            begin errors++; $display("FAIL prio_load_first: data=%h lat=%0d if_rdy=%b, required 000000ab 2 0", d, lat, if_seen); end
        wait_rdy(1'b0, lat, d);
        vectors++;
        if (d !== exp_load(32'h8, 4) || lat != 6)
            begin errors++; $display("FAIL prio_fetch_after: data=%h lat=%0d, required %h 6", d, lat, exp_load(32'h8, 4)); end
        vectors++;
        if (amon.size() < 2 || amon[0] !== 32'h100 || amon[1] !== 32'h8)
            begin errors++; $display("FAIL prio_accept_edge: mem_a samples %h %h, required 00000100 00000008", (amon.size() > 0) ? amon[0] : 32'hx, (amon.size() > 1) ? amon[1] : 32'hx); end
    endtask

    task automatic test_store_word();
        int lat;
        logic [31:0] d;
        start_ls(1'b1, 2'd2, 32'h200, 32'hDEAD_BEEF);
        wait_rdy(1'b1, lat, d);
        model_store(32'h200, 32'hDEAD_BEEF, 4);
        vectors++;
        if (lat != 4) begin errors++; $display("FAIL store_latency: got %0d required 4", lat); end
        vectors++;
        if (pack_log() !== exp_log(32'h200, 32'hDEAD_BEEF, 4))
            begin errors++; $display("FAIL store_bytes: got %h required %h", pack_log(), exp_log(32'h200, 32'hDEAD_BEEF, 4)); end
        @(negedge clk_in);
        vectors++;
        if (ls_rdy !== 1'b0) begin errors++; $display("FAIL store_rdy_pulse: ls_rdy=%b required 0", ls_rdy); end
    endtask

    task automatic test_io_block();
        int lat;
        logic [31:0] d;
        logic [31:0] a0;
        logic bad = 1'b0;
        io_buffer_full = 1'b1;
        a0 = mem_a;
        start_ls(1'b1, 2'd0, 32'h0003_0000, 32'h0000_005A);
        if_en = 1'b1; if_addr = 32'h10;
        repeat (3) begin
            @(negedge clk_in);
            if (mem_wr || if_rdy || ls_rdy || mem_a !== a0) bad = 1'b1;
        end
        vectors++;
        if (bad || wlog.size() != 0)
            begin errors++; $display("FAIL io_blocked: activity=%b writes=%0d, required 0 0", bad, wlog.size()); end
        io_buffer_full = 1'b0;
        wait_rdy(1'b1, lat, d);
        model_store(32'h0003_0000, 32'h5A, 1);
        vectors++;
        if (lat != 1 || pack_log() !== exp_log(32'h0003_0000, 32'h5A, 1))
            begin errors++; $display("FAIL io_single_write: lat=%0d log=%h, required 1 %h", lat, pack_log(), exp_log(32'h0003_0000, 32'h5A, 1)); end
        wait_rdy(1'b0, lat, d);
        vectors++;
        if (d !== exp_load(32'h10, 4)) begin errors++; $display("FAIL io_then_fetch: got %h required %h", d, exp_load(32'h10, 4)); end
    endtask

    task automatic test_flush();
        int lat;
        logic [31:0] d;
        logic [31:0] sd;
        logic seen = 1'b0;
        start_if(32'h20);
        @(negedge clk_in);
        @(negedge clk_in);
        flush = 1'b1; if_en = 1'b0;
        @(negedge clk_in);
        flush = 1'b0;
        repeat (8) begin
            @(negedge clk_in);
            if (if_rdy) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin errors++; $display("FAIL flush_fetch_rdy: if_rdy seen=%b required 0", seen); end
        start_ls(1'b0, 2'd0, 32'h21, 32'h0);
        wait_rdy(1'b1, lat, d);
        vectors++;
        if (lat != 2 || d !== exp_load(32'h21, 1))
            begin errors++; $display("FAIL flush_then_idle: lat=%0d data=%h, required 2 %h", lat, d, exp_load(32'h21, 1)); end
        sd = $urandom;
        start_ls(1'b1, 2'd2, 32'h240, sd);
        @(negedge clk_in);
        @(negedge clk_in);
        flush = 1'b1;
        @(negedge clk_in);
        flush = 1'b0;
        wait_rdy(1'b1, lat, d);
        model_store(32'h240, sd, 4);
        vectors++;
        if (lat != 1 || pack_log() !== exp_log(32'h240, sd, 4))
            begin errors++; $display("FAIL flush_store: lat=%0d log=%h, required 1 %h", lat, pack_log(), exp_log(32'h240, sd, 4)); end
        @(negedge clk_in);
        vectors++;
        if (ls_rdy !== 1'b0) begin errors++; $display("FAIL flush_store_pulse: ls_rdy=%b required 0", ls_rdy); end
    endtask

    task automatic test_stall();
        int lat;
        logic [31:0] d;
        logic [31:0] sd;
        logic wr_seen;
        start_ls(1'b0, 2'd2, 32'h300, 32'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        rdy_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rdy_in = 1'b1;
        wait_rdy(1'b1, lat, d);
        vectors++;
        if (lat != 5 || d !== exp_load(32'h300, 4))
            begin errors++; $display("FAIL stall_load: lat=%0d data=%h, required 5 %h", lat, d, exp_load(32'h300, 4)); end
        sd = $urandom;
        start_ls(1'b1, 2'd2, 32'h340, sd);
        @(negedge clk_in);
        @(negedge clk_in);
        rdy_in = 1'b0;
        #1 wr_seen = mem_wr;
        @(negedge clk_in);
        rdy_in = 1'b1;
        vectors++;
        if (wr_seen !== 1'b0) begin errors++; $display("FAIL stall_wr_gate: mem_wr=%b while frozen, required 0", wr_seen); end
        wait_rdy(1'b1, lat, d);
        model_store(32'h340, sd, 4);
        vectors++;
        if (lat != 2 || pack_log() !== exp_log(32'h340, sd, 4))
            begin errors++; $display("FAIL stall_store: lat=%0d log=%h, required 2 %h", lat, pack_log(), exp_log(32'h340, sd, 4)); end
    endtask

    task automatic test_wrap();
        int lat;
        logic [31:0] d;
        logic [31:0] sd;
        start_ls(1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0);
        wait_rdy(1'b1, lat, d);
        vectors++;
        if (d !== exp_load(32'hFFFF_FFFE, 4)) begin errors++; $display("FAIL wrap_load: got %h required %h", d, exp_load(32'hFFFF_FFFE, 4)); end
        sd = $urandom;
        start_ls(1'b1, 2'd1, 32'hFFFF_FFFF, sd);
        wait_rdy(1'b1, lat, d);
        model_store(32'hFFFF_FFFF, sd, 2);
        vectors++;
        if (lat != 2 || pack_log() !== exp_log(32'hFFFF_FFFF, sd, 2))
            begin errors++; $display("FAIL wrap_store: lat=%0d log=%h, required 2 %h", lat, pack_log(), exp_log(32'hFFFF_FFFF, sd, 2)); end
    endtask

    task automatic test_random();
        int lat;
        int n;
        int kind;
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] sd;
        logic [1:0] sz;
        for (int t = 0; t < 60; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
            kind = $urandom_range(0, 2);
            a = $urandom_range(0, 4095);
            sz = 2'($urandom_range(0, 3));
            sd = $urandom;
            if (kind == 0) begin
                a = a & 32'hFFFF_FFFC;
                start_if(a);
                wait_rdy(1'b0, lat, d);
                vectors++;
                if (lat != 5 || d !== exp_load(a, 4) || wlog.size() != 0)
                    begin errors++; $display("FAIL rand_fetch[%0d]: addr=%h lat=%0d data=%h writes=%0d, required 5 %h 0", t, a, lat, d, wlog.size(), exp_load(a, 4)); end
            end else if (kind == 1) begin
                n = nb(sz);
                start_ls(1'b0, sz, a, 32'h0);
                wait_rdy(1'b1, lat, d);
                vectors++;
                if (lat != n + 1 || d !== exp_load(a, n) || wlog.size() != 0)
                    begin errors++; $display("FAIL rand_load[%0d]: addr=%h size=%0d lat=%0d data=%h writes=%0d, required %0d %h 0", t, a, sz, lat, d, wlog.size(), n + 1, exp_load(a, n)); end
            end else begin
                n = nb(sz);
                start_ls(1'b1, sz, a, sd);
                wait_rdy(1'b1, lat, d);
                model_store(a, sd, n);
                vectors++;
                if (lat != n || pack_log() !== exp_log(a, sd, n))
                    begin errors++; $display("FAIL rand_store[%0d]: lat=%0d log=%h, required %0d %h", t, lat, pack_log(), n, exp_log(a, sd, n)); end
            end
        end
        vectors++;
        if (both_cnt != 0) begin errors++; $display("FAIL both_rdy: %0d cycles with if_rdy and ls_rdy, required 0", both_cnt); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] d;
        start_ls(1'b0, 2'd2, 32'h400, 32'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        #2 rst_in = 1'b0;
        #1;
        vectors++;
        if ({mem_a, mem_dout, mem_wr, if_rdy, if_data, ls_rdy, ls_rdata} !== '0)
            begin errors++; $display("FAIL reset_mid: mem_a=%h dout=%h wr=%b if_rdy=%b if_data=%h ls_rdy=%b ls_rdata=%h, required all 0", mem_a, mem_dout, mem_wr, if_rdy, if_data, ls_rdy, ls_rdata); end
        ls_en = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        start_ls(1'b0, 2'd0, 32'h401, 32'h0);
        wait_rdy(1'b1, lat, d);
        vectors++;
        if (lat != 2 || d !== exp_load(32'h401, 1))
            begin errors++; $display("FAIL reset_recover: lat=%0d data=%h, required 2 %h", lat, d, exp_load(32'h401, 1)); end
    endtask

    initial begin
        logic [7:0] v;
        for (int i = 0; i < 4096; i++) begin
            v = 8'($urandom);
            ram[i] = v;
            model[i] = v;
        end
        test_reset();
        test_fetch();
        test_priority();
        test_store_word();
        test_io_block();
        test_flush();
        test_stall();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
# memory_controller

Memory-side responder for the core's fetch and load/store ports. It accepts word instruction-fetch requests from the decoder and byte, half and word load/store requests from the load-store buffer. It serialises each request onto the byte-wide RAM/IO bus and returns one `*_rdy` pulse with the assembled data. It sits between the decoder/LSB and the external `mem_*` pins.

## Interface
- `IO_BASE`, default 32'h0003_0000: writes with `addr[31:16] == IO_BASE[31:16]` are IO writes and are gated by `io_buffer_full`.

Ports:
- `clk_in`  in  1  clock; all logic on the rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  global enable; low freezes the block.
- `flush`  in  1  misprediction flush, sampled on the clock edge.
- `mem_din`  in  8  RAM read byte.
- `mem_dout`  out  8  RAM write byte.
- `mem_a`  out  32  RAM byte address.
- `mem_wr`  out  1  write strobe: 1 = write, 0 = read.
- `io_buffer_full`  in  1  IO write buffer cannot accept.
- `if_en`  in  1  fetch request; held high until `if_rdy`.
- `if_addr`  in  32  fetch address, word-aligned.
- `if_rdy`  out  1  one-cycle fetch-complete pulse.
- `if_data`  out  32  fetched instruction, little-endian; valid while `if_rdy` is high.
- `ls_en`  in  1  load/store request; held high until `ls_rdy`.
- `ls_wr`  in  1  1 = store, 0 = load.
- `ls_size`  in  2  access size: 0 = byte, 1 = half, 2 = word (3 is treated as word).
- `ls_addr`  in  32  byte address; no alignment requirement.
- `ls_wdata`  in  32  store data; bytes are taken LSB-first.
- `ls_rdy`  out  1  one-cycle completion pulse, for loads and stores.
- `ls_rdata`  out  32  load data, zero-extended; the LSB performs sign extension.

## Operation
States: IDLE, READ, WRITE, DONE. A request's fields are latched on acceptance; later changes on the request inputs are ignored until DONE.

IDLE:
- `ls_en` has priority over `if_en`; the LSB drains committed stores, which avoids deadlock.
- A store to the IO range is not accepted while `io_buffer_full` is high. A pending fetch is also not accepted over a blocked store, so the store keeps its priority.
- An accepted load or fetch goes to READ; an accepted store goes to WRITE.

READ, n bytes:
- At the accept edge E0, `mem_a` is registered to `addr`.
- At edge Ek (k = 1..n-1), `mem_a` becomes `addr+k`.
- RAM latency is one cycle, so byte k is captured from `mem_din` at edge E(k+2) into result bits [8k+7:8k].
- At edge E(n+1), the last byte is captured, the matching `*_rdy` is set, and the state becomes DONE.
- Unused upper result bits are 0.

WRITE, n bytes:
- At edge Ek (k = 0..n-1), the block registers `mem_wr`=1, `mem_a`=`addr+k` and `mem_dout`=byte k.
- At edge En, `mem_wr` goes to 0, `ls_rdy` is set, and the state becomes DONE.

DONE:
- Lasts exactly one cycle with `*_rdy`=1, then returns to IDLE.
- No request is accepted in DONE; the requester's `en` is still high during the rdy cycle.

Address arithmetic is 32-bit and wraps modulo 2^32.

`flush` sampled high:
- In READ, from either port: abort, return to IDLE, no rdy pulse.
- In DONE: `*_rdy` clears and the state returns to IDLE.
- In IDLE: no acceptance on that edge.
- In WRITE: ignored; committed stores always complete.

`rdy_in` low:
- No state register changes, and `mem_wr` is forced to 0 combinationally.
- In READ, the access restarts from byte 0 on the first edge with `rdy_in` high; that edge acts as E0 again.
- In WRITE, the current byte is re-presented when `rdy_in` returns.

## Timing
- Reset (`rst_in` low, asynchronous, no clock needed):
  - State is IDLE.
  - `mem_a`, `mem_dout`, `mem_wr`, `if_rdy`, `if_data`, `ls_rdy` and `ls_rdata` are all 0.
  - Reset mid-access abandons the access.
- Latency from accept edge E0 to the `*_rdy` cycle:
  - Read: ends at edge E(n+1), so 5 edges for a word fetch or word load, 3 for a half load, 2 for a byte load.
  - Write: ends at edge En, so 4, 2 or 1 edges.
- Next acceptance is no earlier than the edge after the DONE cycle.
- `mem_wr` is high for exactly n consecutive unstalled cycles per store and is never high during a read.
- `if_rdy` and `ls_rdy` are never high in the same cycle.

## Test plan
- Word fetch at 0x0000_0004, RAM bytes 13 05 10 00:
  - `mem_a` steps 0x4, 0x5, 0x6, 0x7.
  - `if_data`=0x0010_0513, with `if_rdy` high for one cycle, 5 edges after accept.
  - `mem_wr` stays 0.
- `if_en` and `ls_en` (byte load at 0x100 = 0xAB) asserted in the same cycle:
  - `ls_rdata`=0x0000_00AB first.
  - The fetch is accepted after DONE.
- Word store 0xDEAD_BEEF to 0x200:
  - `mem_a` 0x200..0x203, `mem_dout` EF BE AD DE, `mem_wr` high for 4 cycles.
  - `ls_rdy` pulses once.
- Byte store to 0x30000 with `io_buffer_full` high for 3 cycles:
  - No `mem_wr` until it drops.
  - Then a single write cycle.
- `flush` after 2 bytes of a fetch → no `if_rdy`, state IDLE. `flush` during a word store → all 4 bytes are written and `ls_rdy` pulses.
- `rdy_in` low for 2 cycles mid-word-load → the load restarts and returns correct data. `rst_in` low mid-load → every output is 0 immediately.
